lcd_fb_arbiter: RTL and testbench
=================================

# lcd_fb_arbiter

Single-port frame-buffer arbiter for the 480x272 LCD panel. It shares one synchronous RAM port between the display scan and a host write stream. During the active area it turns the timing generator's enable/column/row into frame-buffer reads and returns a latency-matched pixel and data enable to the panel. During blanking it drains a small host write FIFO into the same RAM port.

## Interface
Parameters:
- PIXEL_W, 24: pixel width (RGB888).
- H_ACTIVE, 480: pixels per line; also the row stride in the address map.
- V_ACTIVE, 272: lines per frame.
- ADDR_W, 17: frame-buffer address width; 480*272 = 130560 words.
- FIFO_DEPTH, 4: host write FIFO entries; must be a power of 2.

Ports:
- i_clk, in, 1: pixel clock; the only clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_de, in, 1: active-area enable from the timing generator.
- i_col, in, 9: active column, 0..479.
- i_row, in, 9: active row, 0..271.
- i_host_valid, in, 1: host write request.
- o_host_ready, out, 1: FIFO not full; a write is accepted when valid and ready are both high.
- i_host_addr, in, ADDR_W: host pixel address.
- i_host_data, in, PIXEL_W: host pixel data.
- o_mem_addr, out, ADDR_W: RAM address, registered.
- o_mem_we, out, 1: RAM write strobe, registered.
- o_mem_wdata, out, PIXEL_W: RAM write data, registered.
- i_mem_rdata, in, PIXEL_W: RAM read data, valid 1 cycle after the address.
- o_de, out, 1: panel data enable, delayed.
- o_pixel, out, PIXEL_W: panel pixel.
- o_wr_drop, out, 1: 1-cycle pulse when an out-of-range host write is discarded.

## Operation
- Arbitration is decided each cycle from i_de. The display always wins; no host write is ever issued while i_de = 1.
- Display read, i_de = 1:
  - o_mem_addr <= i_row*480 + i_col, using shift-subtract ((row<<9) - (row<<5) + col) at ADDR_W bits. No multiplier.
  - o_mem_we <= 0.
  - The FIFO does not pop.
- Host write, i_de = 0 and FIFO non-empty:
  - Pop the head entry.
  - If its address is below H_ACTIVE*V_ACTIVE: o_mem_we <= 1, o_mem_addr <= entry addr, o_mem_wdata <= entry data.
  - Otherwise: o_mem_we <= 0 and o_wr_drop <= 1 for one cycle. The entry is consumed either way.
- Idle, i_de = 0 and FIFO empty: o_mem_we <= 0; o_mem_addr holds its value.
- FIFO behaviour:
  - Circular, with a count register of width log2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle leaves the count unchanged.
  - o_host_ready = (count != FIFO_DEPTH), combinational from the count register.
  - Writes leave the FIFO in order; no write is lost or reordered.
- Display return path:
  - A 3-stage i_de delay line produces o_de.
  - o_pixel <= i_mem_rdata when the 2-stage-delayed de is 1, else 0. o_pixel is 0 whenever o_de = 0.
- i_col and i_row are not range-checked; they are trusted from the timing generator.

## Timing
- Read latency: i_de/i_col/i_row in cycle N gives o_mem_addr in N+1, RAM data in N+2, and o_de/o_pixel in N+3. There is no bubble; one pixel per clock is sustained across a full 480-pixel line.
- Write latency: a host handshake in cycle N puts the entry in the FIFO in N+1. The earliest possible o_mem_we is N+2, provided that i_de = 0 in N+1.
- Host drain bandwidth:
  - 45 writes per line during horizontal blanking.
  - 525 writes per line during the 18 vertical-blanking lines.
  - Zero writes during active pixels; the host sees o_host_ready = 0 once the FIFO fills.
- Transitions:
  - If i_de rises in the same cycle the FIFO is non-empty, the read wins and the entry stays in the FIFO.
  - If i_de falls, a pop may occur in that same cycle.
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - FIFO empty, so o_host_ready = 1.
  - o_mem_addr = 0, o_mem_we = 0, o_mem_wdata = 0.
  - o_de = 0, o_pixel = 0, o_wr_drop = 0.
  - All de delay stages are 0.
  - Reset mid-line or mid-write discards the FIFO contents.

## Test plan
- Scan readout: preload RAM with data = address, run one frame of timing. Pixel (col 0, row 0) returns 0. (479, 271) returns 130559. (5, 1) returns 485. o_de is exactly i_de delayed 3 cycles.
- Blanking write: hold i_de = 0, push addr 100, data 0xABCDEF in cycle N. Expect o_mem_we = 1, addr 100, wdata 0xABCDEF in cycle N+2. A later readout of (100, 0) returns 0xABCDEF.
- Active-area stall: push 5 writes while i_de = 1. The first 4 are accepted and o_host_ready = 0 from then on. No o_mem_we during active cycles. All 4 writes drain in order in the first 4 blanking cycles, then the 5th is accepted.
- Simultaneous push/pop: FIFO holds 2 entries with i_de = 0, push each cycle. The count stays at 2, each cycle writes the oldest entry, and the order is preserved.
- Out-of-range: push addr 130560 during blanking. Expect o_wr_drop high for 1 cycle, o_mem_we = 0, and the FIFO count decremented.
- Reset mid-operation: with 3 entries queued and i_de = 1, pull i_rst_n low for 1 cycle. All outputs read 0, o_host_ready = 1, and no queued write ever reaches the RAM.

Source files
------------

// File: rtl/lcd_fb_arbiter.sv
// rtl/lcd_fb_arbiter.sv - single RAM port shared between panel scan-out and a host write FIFO
module lcd_fb_arbiter #(
    parameter int PIXEL_W    = 24,
    parameter int H_ACTIVE   = 480,
    parameter int V_ACTIVE   = 272,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_de,
    input  logic [8:0]         i_col,
    input  logic [8:0]         i_row,
    input  logic               i_host_valid,
    output logic               o_host_ready,
    input  logic [ADDR_W-1:0]  i_host_addr,
    input  logic [PIXEL_W-1:0] i_host_data,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic               o_mem_we,
    output logic [PIXEL_W-1:0] o_mem_wdata,
    input  logic [PIXEL_W-1:0] i_mem_rdata,
    output logic               o_de,
    output logic [PIXEL_W-1:0] o_pixel,
    output logic               o_wr_drop
);

    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] FB_WORDS  = ADDR_W'(H_ACTIVE * V_ACTIVE);

    // Host write FIFO storage (no reset: validity is carried by the count)
    logic [ADDR_W-1:0]  fifo_addr_q [FIFO_DEPTH];
    logic [PIXEL_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // RAM port registers
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_we_q, mem_we_d;
    logic [PIXEL_W-1:0] mem_wdata_q, mem_wdata_d;
    logic               wr_drop_q, wr_drop_d;

    // Display return path
    logic [2:0]         de_dly_q, de_dly_d;
    logic [PIXEL_W-1:0] pixel_q, pixel_d;

    logic               push;
    logic               pop;
    logic [ADDR_W-1:0]  head_addr;
    logic [PIXEL_W-1:0] head_data;
    logic               head_in_range;
    logic [ADDR_W-1:0]  row_ext;
    logic [ADDR_W-1:0]  col_ext;
    logic [ADDR_W-1:0]  scan_addr;

    assign o_host_ready  = (count_q != FIFO_FULL);
    assign push          = i_host_valid && o_host_ready;
    // The display owns the port whenever i_de is high; the FIFO only drains in blanking.
    assign pop           = !i_de && (count_q != '0);

    assign head_addr     = fifo_addr_q[rd_ptr_q];
    assign head_data     = fifo_data_q[rd_ptr_q];
    assign head_in_range = (head_addr < FB_WORDS);

    // Row stride of 480 = 512 - 32, so the address needs only shifts and adds.
    // Intermediate wrap at ADDR_W bits cancels out because the final sum fits.
    assign row_ext   = ADDR_W'(i_row);
    assign col_ext   = ADDR_W'(i_col);
    assign scan_addr = (row_ext << 9) - (row_ext << 5) + col_ext;

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Port arbitration: scan read, host write, drop, or idle hold
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_drop_d   = 1'b0;
        if (i_de) begin
            mem_addr_d = scan_addr;
        end else if (pop) begin
            if (head_in_range) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = head_addr;
                mem_wdata_d = head_data;
            end else begin
                wr_drop_d = 1'b1;
            end
        end
    end

    // Latency-match de to the RAM read and blank the pixel outside the active area
    always_comb begin
        de_dly_d = {de_dly_q[1:0], i_de};
        pixel_d  = de_dly_q[1] ? i_mem_rdata : '0;
    end

    // FIFO storage write
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= i_host_addr;
            fifo_data_q[wr_ptr_q] <= i_host_data;
        end
    end

    // State registers; reset empties the FIFO and silences the RAM port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_drop_q   <= 1'b0;
            de_dly_q    <= '0;
            pixel_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wr_drop_q   <= wr_drop_d;
            de_dly_q    <= de_dly_d;
            pixel_q     <= pixel_d;
        end
    end

    assign o_mem_addr  = mem_addr_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_wr_drop   = wr_drop_q;
    assign o_de        = de_dly_q[2];
    assign o_pixel     = pixel_q;

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// tb/tb_lcd_fb_arbiter.sv - self-checking bench for lcd_fb_arbiter
module tb_lcd_fb_arbiter;

    localparam int PW    = 24;
    localparam int AW    = 17;
    localparam int HA    = 480;
    localparam int VA    = 272;
    localparam int FB    = HA * VA;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [PW-1:0] d;
    } wr_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          de    = 1'b0;
    logic [8:0]    col   = '0;
    logic [8:0]    row   = '0;
    logic          hv    = 1'b0;
    logic          hr;
    logic [AW-1:0] haddr = '0;
    logic [PW-1:0] hdata = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [PW-1:0] mem_wdata;
    logic [PW-1:0] mem_rdata = '0;
    logic          o_de;
    logic [PW-1:0] o_pixel;
    logic          wr_drop;

    int n_chk = 0;
    int n_pass = 0;
    bit fb_patched = 1'b0;

    always #5 clk = ~clk;

    lcd_fb_arbiter #(
        .PIXEL_W(PW), .H_ACTIVE(HA), .V_ACTIVE(VA), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_de(de), .i_col(col), .i_row(row),
        .i_host_valid(hv), .o_host_ready(hr), .i_host_addr(haddr), .i_host_data(hdata),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_de(o_de), .o_pixel(o_pixel), .o_wr_drop(wr_drop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Synchronous RAM preloaded with data = address, read data one cycle after address
    logic [PW-1:0] ram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = PW'(i);
        forever begin
            @(posedge clk);
            mem_rdata <= ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_wdata;
        end
    end

    // Reference model: a plain queue for the FIFO, an image of the frame buffer,
    // and a 3-deep history of what the panel must show.
    wr_t           mq[$];
    logic [PW-1:0] ref_fb [0:FB-1];
    logic [AW-1:0] m_addr  = '0;
    logic          m_we    = 1'b0;
    logic [PW-1:0] m_wdata = '0;
    logic          m_drop  = 1'b0;
    logic          m_de  [3];
    logic [PW-1:0] m_pix [3];
    int            m_col [3];
    int            m_row [3];

    initial begin
        for (int i = 0; i < FB; i++) ref_fb[i] = PW'(i);
        for (int i = 0; i < 3; i++) begin
            m_de[i] = 1'b0; m_pix[i] = '0; m_col[i] = 0; m_row[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_addr = '0; m_we = 1'b0; m_wdata = '0; m_drop = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    m_de[i] = 1'b0; m_pix[i] = '0; m_col[i] = 0; m_row[i] = 0;
                end
            end else begin
                bit  room;
                wr_t h;
                wr_t n;
                int  a;
                room   = (mq.size() < DEPTH);
                m_we   = 1'b0;
                m_drop = 1'b0;
                for (int i = 2; i > 0; i--) begin
                    m_de[i] = m_de[i-1]; m_pix[i] = m_pix[i-1];
                    m_col[i] = m_col[i-1]; m_row[i] = m_row[i-1];
                end
                m_de[0] = de; m_pix[0] = '0; m_col[0] = int'(col); m_row[0] = int'(row);
                if (de) begin
                    a        = int'(row) * HA + int'(col);
                    m_addr   = AW'(a);
                    m_pix[0] = ref_fb[a];
                end else if (mq.size() > 0) begin
                    h = mq.pop_front();
                    if (int'(h.a) < FB) begin
                        m_we    = 1'b1;
                        m_addr  = h.a;
                        m_wdata = h.d;
                        ref_fb[int'(h.a)] = h.d;
                    end else begin
                        m_drop = 1'b1;
                    end
                end
                if (hv && room) begin
                    n.a = haddr; n.d = hdata;
                    mq.push_back(n);
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus literal pixel pins
    initial forever begin
        @(negedge clk);
        chk("host_ready", 32'(hr), 32'(mq.size() < DEPTH));
        chk("mem_we",     32'(mem_we),    32'(m_we));
        chk("mem_addr",   32'(mem_addr),  32'(m_addr));
        chk("mem_wdata",  32'(mem_wdata), 32'(m_wdata));
        chk("wr_drop",    32'(wr_drop),   32'(m_drop));
        chk("o_de",       32'(o_de),      32'(m_de[2]));
        chk("o_pixel",    32'(o_pixel),   32'(m_pix[2]));
        if (m_de[2]) begin
            if (m_col[2] == 0 && m_row[2] == 0)     chk("pix_0_0", 32'(o_pixel), 32'd0);
            if (m_col[2] == 5 && m_row[2] == 1)     chk("pix_5_1", 32'(o_pixel), 32'd485);
            if (m_col[2] == 479 && m_row[2] == 271) chk("pix_479_271", 32'(o_pixel), 32'd130559);
            if (m_col[2] == 100 && m_row[2] == 0)
                chk("pix_100_0", 32'(o_pixel), fb_patched ? 32'hABCDEF : 32'd100);
        end
    end

    // Stimulus: host writes waiting to be offered, one per cycle
    wr_t pend[$];

    task automatic tick(input bit d, input int c, input int r);
        bit acc;
        de  = d;
        col = 9'(c);
        row = 9'(r);
        if (pend.size() > 0) begin
            hv = 1'b1; haddr = pend[0].a; hdata = pend[0].d;
        end else begin
            hv = 1'b0; haddr = '0; hdata = '0;
        end
        acc = hv && hr;
        @(negedge clk);
        #1;
        if (acc) pend.delete(0);
    endtask

    task automatic scan_line(input int r, input int blank);
        for (int c = 0; c < HA; c++) tick(1'b1, c, r);
        for (int b = 0; b < blank; b++) tick(1'b0, 0, 0);
    endtask

    task automatic queue_wr(input int a, input int d);
        wr_t w;
        w.a = AW'(a);
        w.d = PW'(d);
        pend.push_back(w);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(hr),        32'd1);
        chk({tag, "_we"},    32'(mem_we),    32'd0);
        chk({tag, "_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_de"},    32'(o_de),      32'd0);
        chk({tag, "_pixel"}, 32'(o_pixel),   32'd0);
        chk({tag, "_drop"},  32'(wr_drop),   32'd0);
    endtask

    initial begin
        int we_seen;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Scan readout of a few representative lines
        scan_line(0, 4);
        scan_line(1, 4);
        scan_line(271, 4);

        // Blanking write: handshake in N, RAM write in N+2
        queue_wr(100, 24'hABCDEF);
        tick(1'b0, 0, 0);
        chk("bw_we_n1", 32'(mem_we), 32'd0);
        tick(1'b0, 0, 0);
        chk("bw_we_n2",    32'(mem_we),    32'd1);
        chk("bw_addr_n2",  32'(mem_addr),  32'd100);
        chk("bw_wdata_n2", 32'(mem_wdata), 32'hABCDEF);
        fb_patched = 1'b1;
        tick(1'b0, 0, 0);
        scan_line(0, 4);

        // Active-area stall: five offered, four accepted, drained in order at blanking
        for (int i = 0; i < 5; i++) queue_wr(200 + i, 24'h100000 + i);
        for (int c = 0; c < 10; c++) tick(1'b1, c, 2);
        chk("stall_ready",   32'(hr),          32'd0);
        chk("stall_pending", 32'(pend.size()), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 0, 0);
            chk("drain_we",    32'(mem_we),    32'd1);
            chk("drain_addr",  32'(mem_addr),  32'(200 + k));
            chk("drain_wdata", 32'(mem_wdata), 32'(24'h100000 + k));
        end
        chk("stall_5th_taken", 32'(pend.size()), 32'd0);
        tick(1'b0, 0, 0);

        // Simultaneous push/pop with two entries already queued
        for (int i = 0; i < 8; i++) queue_wr(300 + i, 24'h200000 + i);
        tick(1'b1, 0, 3);
        tick(1'b1, 1, 3);
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 0, 0);
            chk("pp_addr",  32'(mem_addr), 32'(300 + k));
            chk("pp_ready", 32'(hr),       32'd1);
        end
        repeat (4) tick(1'b0, 0, 0);

        // Out-of-range host write is consumed and flagged
        queue_wr(FB, 24'h123456);
        tick(1'b0, 0, 0);
        chk("oor_drop_n1", 32'(wr_drop), 32'd0);
        tick(1'b0, 0, 0);
        chk("oor_drop_n2", 32'(wr_drop), 32'd1);
        chk("oor_we_n2",   32'(mem_we),  32'd0);
        tick(1'b0, 0, 0);
        chk("oor_drop_n3", 32'(wr_drop), 32'd0);
        chk("oor_ready",   32'(hr),      32'd1);

        // Reset with three writes queued during the active area
        for (int i = 0; i < 3; i++) queue_wr(400 + i, 24'h300000 + i);
        for (int c = 0; c < 3; c++) tick(1'b1, c, 4);
        chk("rst_pre_full", 32'(hr), 32'd1);
        hv = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        we_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 0, 0);
            we_seen += int'(mem_we);
        end
        chk("rst_no_write", 32'(we_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
